// File: rtl/rotary_encoder_counter.sv
// Multi-channel quadrature encoder front end: per-channel sync, debounce filter,
// direction decode and wrap/saturate position counter.
//
//   state  | meaning
//   IDLE   | resting at detent 00, no partial cycle
//   CW1    | 01 reached moving clockwise
//   CW2    | 11 reached moving clockwise
//   CW3    | 10 reached moving clockwise, 00 next completes a CW detent
//   CCW1   | 10 reached moving counterclockwise
//   CCW2   | 11 reached moving counterclockwise
//   CCW3   | 01 reached moving counterclockwise, 00 next completes a CCW detent
//   RESYNC | after an illegal jump, waiting for 00 before decoding again
module rotary_encoder_counter #(
  parameter int CHANNELS      = 2,
  parameter int COUNT_WIDTH   = 8,
  parameter int FILTER_CYCLES = 4,
  parameter int STEP_MODE     = 0,
  parameter int SATURATE      = 0
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [CHANNELS-1:0]             iv_phase_a,
  input  logic [CHANNELS-1:0]             iv_phase_b,
  input  logic [CHANNELS-1:0]             iv_clear,
  output logic [CHANNELS*COUNT_WIDTH-1:0] ov_position,
  output logic [CHANNELS-1:0]             ov_step,
  output logic [CHANNELS-1:0]             ov_step_cw,
  output logic [CHANNELS-1:0]             ov_err
);

  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [COUNT_WIDTH-1:0] POS_MAX = '1;

  typedef enum logic [2:0] {IDLE, CW1, CW2, CW3, CCW1, CCW2, CCW3, RESYNC} state_t;

  function automatic logic [1:0] cw_next(input logic [1:0] ph);
    case (ph)
      2'b00:   cw_next = 2'b01;
      2'b01:   cw_next = 2'b11;
      2'b11:   cw_next = 2'b10;
      default: cw_next = 2'b00;
    endcase
  endfunction

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [1:0]             sync_1, sync_2, ph_last, ph_filt, ph_prev;
    logic [CNT_W-1:0]       filt_cnt, run_len;
    state_t                 state;
    logic [COUNT_WIDTH-1:0] pos;
    logic                   step, step_cw, err;
    logic                   trans, illegal, step_now, cw_now;

    // run_len counts the current sample: consecutive identical samples that differ from ph_filt
    always_comb begin
      run_len = '0;
      if (sync_2 != ph_filt)
        run_len = (sync_2 != ph_last) ? CNT_W'(1) : filt_cnt + CNT_W'(1);
    end

    assign trans   = (ph_filt != ph_prev);
    assign illegal = trans && ((ph_filt ^ ph_prev) == 2'b11);

    always_comb begin
      step_now = 1'b0;
      cw_now   = 1'b0;
      if (trans && !illegal) begin
        if (STEP_MODE != 0) begin
          step_now = 1'b1;
          cw_now   = (ph_filt == cw_next(ph_prev));
        end else if (ph_filt == 2'b00) begin
          step_now = (state == CW3) || (state == CCW3);
          cw_now   = (state == CW3);
        end
      end
    end

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        sync_1   <= 2'b00;
        sync_2   <= 2'b00;
        ph_last  <= 2'b00;
        ph_filt  <= 2'b00;
        ph_prev  <= 2'b00;
        filt_cnt <= '0;
        state    <= IDLE;
        pos      <= '0;
        step     <= 1'b0;
        step_cw  <= 1'b0;
        err      <= 1'b0;
      end else begin
        sync_1  <= {iv_phase_b[n], iv_phase_a[n]};
        sync_2  <= sync_1;
        ph_last <= sync_2;
        if (run_len == CNT_W'(FILTER_CYCLES)) begin
          ph_filt  <= sync_2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= run_len;
        end
        ph_prev <= ph_filt;

        step    <= step_now;
        step_cw <= cw_now;
        err     <= illegal;

        if (trans && STEP_MODE == 0) begin
          if (illegal) begin
            state <= (ph_filt == 2'b00) ? IDLE : RESYNC;
          end else begin
            case (state)
              IDLE:   state <= (ph_filt == 2'b01) ? CW1 : CCW1;
              CW1:    state <= (ph_filt == 2'b11) ? CW2 : IDLE;
              CW2:    state <= (ph_filt == 2'b10) ? CW3 : CW1;
              CW3:    state <= (ph_filt == 2'b00) ? IDLE : CW2;
              CCW1:   state <= (ph_filt == 2'b11) ? CCW2 : IDLE;
              CCW2:   state <= (ph_filt == 2'b01) ? CCW3 : CCW1;
              CCW3:   state <= (ph_filt == 2'b00) ? IDLE : CCW2;
              RESYNC: if (ph_filt == 2'b00) state <= IDLE;
            endcase
          end
        end

        // clear overrides a coincident step, though the strobe still goes out
        if (iv_clear[n]) begin
          pos <= '0;
        end else if (step_now) begin
          if (cw_now)
            pos <= (SATURATE != 0 && pos == POS_MAX) ? pos : pos + COUNT_WIDTH'(1);
          else
            pos <= (SATURATE != 0 && pos == '0) ? pos : pos - COUNT_WIDTH'(1);
        end
      end
    end

    assign ov_position[n*COUNT_WIDTH +: COUNT_WIDTH] = pos;
    assign ov_step[n]    = step;
    assign ov_step_cw[n] = step_cw;
    assign ov_err[n]     = err;
  end

endmodule

// File: tb/tb_rotary_encoder_counter.sv
// Bench: three encoder configurations (wrap detent, saturate detent, wrap quarter)
// driven in parallel and compared every cycle against a displacement-based model.
module tb_rotary_encoder_counter;
  localparam int CH = 2;
  localparam int FC = 2;
  localparam int NU = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] pa = '0, pb = '0, clr = '0;
  logic [3:0]    pos_w [NU];
  logic [CH-1:0] stp_w [NU];
  logic [CH-1:0] cw_w  [NU];
  logic [CH-1:0] err_w [NU];

  always #5 clk = ~clk;

  rotary_encoder_counter #(.CHANNELS(2), .COUNT_WIDTH(2), .FILTER_CYCLES(2), .STEP_MODE(0), .SATURATE(0))
    u_wrap (.i_clk(clk), .i_rst_n(rst_n), .iv_phase_a(pa), .iv_phase_b(pb), .iv_clear(clr),
            .ov_position(pos_w[0]), .ov_step(stp_w[0]), .ov_step_cw(cw_w[0]), .ov_err(err_w[0]));
  rotary_encoder_counter #(.CHANNELS(2), .COUNT_WIDTH(2), .FILTER_CYCLES(2), .STEP_MODE(0), .SATURATE(1))
    u_sat  (.i_clk(clk), .i_rst_n(rst_n), .iv_phase_a(pa), .iv_phase_b(pb), .iv_clear(clr),
            .ov_position(pos_w[1]), .ov_step(stp_w[1]), .ov_step_cw(cw_w[1]), .ov_err(err_w[1]));
  rotary_encoder_counter #(.CHANNELS(2), .COUNT_WIDTH(2), .FILTER_CYCLES(2), .STEP_MODE(1), .SATURATE(0))
    u_qtr  (.i_clk(clk), .i_rst_n(rst_n), .iv_phase_a(pa), .iv_phase_b(pb), .iv_clear(clr),
            .ov_position(pos_w[2]), .ov_step(stp_w[2]), .ov_step_cw(cw_w[2]), .ov_err(err_w[2]));

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // model state: raw-sample delay, recent synchronised samples, accepted phase, displacement
  int m_d1 [NU][CH];
  int m_d2 [NU][CH];
  int m_h  [NU][CH][FC];
  int m_filt [NU][CH];
  int m_seen [NU][CH];
  int m_disp [NU][CH];
  int m_pos  [NU][CH];
  bit m_resync [NU][CH];
  bit m_step [NU][CH];
  bit m_cw   [NU][CH];
  bit m_err  [NU][CH];

  int n_step   [NU][CH];
  int n_err    [NU][CH];
  int step_cyc [NU][CH];
  int samp [CH];

  int cwq  [4] = '{1, 3, 2, 0};
  int ccwq [4] = '{2, 3, 1, 0};
  int gseq [4] = '{0, 1, 3, 2};

  function automatic int gidx(int v);
    case (v)
      1:       return 1;
      3:       return 2;
      2:       return 3;
      default: return 0;
    endcase
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // unit 0: wrap detent, unit 1: saturate detent, unit 2: wrap quarter
  task automatic model_ch(int u, int c);
    int s, d, dir;
    bit same;
    if (!rst_n) begin
      m_d1[u][c] = 0; m_d2[u][c] = 0;
      for (int k = 0; k < FC; k++) m_h[u][c][k] = 0;
      m_filt[u][c] = 0; m_seen[u][c] = 0; m_disp[u][c] = 0; m_pos[u][c] = 0;
      m_resync[u][c] = 0; m_step[u][c] = 0; m_cw[u][c] = 0; m_err[u][c] = 0;
      return;
    end
    m_step[u][c] = 0; m_cw[u][c] = 0; m_err[u][c] = 0;
    if (m_filt[u][c] != m_seen[u][c]) begin
      d = (gidx(m_filt[u][c]) - gidx(m_seen[u][c]) + 4) % 4;
      if (d == 2) begin
        m_err[u][c] = 1;
        m_resync[u][c] = (m_filt[u][c] != 0);
        m_disp[u][c] = 0;
      end else begin
        dir = (d == 1) ? 1 : -1;
        if (u == 2) begin
          m_step[u][c] = 1;
          m_cw[u][c] = (d == 1);
        end else if (m_resync[u][c]) begin
          if (m_filt[u][c] == 0) m_resync[u][c] = 0;
        end else begin
          m_disp[u][c] += dir;
          if (m_filt[u][c] == 0) begin
            if (m_disp[u][c] == 4) begin m_step[u][c] = 1; m_cw[u][c] = 1; end
            else if (m_disp[u][c] == -4) begin m_step[u][c] = 1; m_cw[u][c] = 0; end
            m_disp[u][c] = 0;
          end
        end
      end
      m_seen[u][c] = m_filt[u][c];
    end
    if (m_step[u][c]) begin
      if (m_cw[u][c]) m_pos[u][c] = (u == 1) ? ((m_pos[u][c] == 3) ? 3 : m_pos[u][c] + 1) : (m_pos[u][c] + 1) % 4;
      else            m_pos[u][c] = (u == 1) ? ((m_pos[u][c] == 0) ? 0 : m_pos[u][c] - 1) : (m_pos[u][c] + 3) % 4;
    end
    if (clr[c]) m_pos[u][c] = 0;
    s = m_d2[u][c];
    for (int k = FC - 1; k > 0; k--) m_h[u][c][k] = m_h[u][c][k-1];
    m_h[u][c][0] = s;
    same = 1;
    for (int k = 0; k < FC; k++) if (m_h[u][c][k] != s) same = 0;
    if (same && s != m_filt[u][c]) m_filt[u][c] = s;
    m_d2[u][c] = m_d1[u][c];
    m_d1[u][c] = {30'd0, pb[c], pa[c]};
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int u = 0; u < NU; u++)
      for (int c = 0; c < CH; c++) model_ch(u, c);
  end

  always @(posedge clk) begin
    #1;
    for (int u = 0; u < NU; u++) begin
      for (int c = 0; c < CH; c++) begin
        chk($sformatf("u%0d.ch%0d.pos", u, c), int'(pos_w[u][c*2 +: 2]), m_pos[u][c]);
        chk($sformatf("u%0d.ch%0d.step", u, c), int'(stp_w[u][c]), int'(m_step[u][c]));
        if (m_step[u][c]) chk($sformatf("u%0d.ch%0d.step_cw", u, c), int'(cw_w[u][c]), int'(m_cw[u][c]));
        chk($sformatf("u%0d.ch%0d.err", u, c), int'(err_w[u][c]), int'(m_err[u][c]));
        if (stp_w[u][c]) begin n_step[u][c]++; step_cyc[u][c] = cyc; end
        if (err_w[u][c]) n_err[u][c]++;
      end
    end
  end

  task automatic set_ph(int c, int v);
    pa[c] = v[0];
    pb[c] = v[1];
  endtask

  task automatic hold(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic seq(int c, int v, int n);
    set_ph(c, v);
    if (v == 0) samp[c] = cyc + 1;
    hold(n);
  endtask

  task automatic cycle4(int c, bit cw, int n);
    for (int i = 0; i < 4; i++) seq(c, cw ? cwq[i] : ccwq[i], n);
  endtask

  int gi [CH];
  int clr_cyc;
  int r;

  initial begin
    for (int u = 0; u < NU; u++)
      for (int c = 0; c < CH; c++) begin n_step[u][c] = 0; n_err[u][c] = 0; step_cyc[u][c] = -100; end

    hold(3);
    for (int u = 0; u < NU; u++) begin
      chk($sformatf("reset.u%0d.pos", u), int'(pos_w[u]), 0);
      chk($sformatf("reset.u%0d.step", u), int'(stp_w[u]), 0);
      chk($sformatf("reset.u%0d.err", u), int'(err_w[u]), 0);
    end
    rst_n = 1'b1;
    hold(4);

    for (int k = 0; k < 3; k++) begin
      cycle4(0, 1'b1, 6);
      chk("cw.latency", step_cyc[0][0] - samp[0] + 1, 5);
    end
    chk("cw3.u0.ch0.pos", int'(pos_w[0][1:0]), 3);
    chk("cw3.u0.ch0.steps", n_step[0][0], 3);
    chk("cw3.u0.ch1.pos", int'(pos_w[0][3:2]), 0);
    chk("cw3.u0.ch1.steps", n_step[0][1], 0);

    cycle4(0, 1'b1, 6);
    chk("wrap.u0.ch0.pos", int'(pos_w[0][1:0]), 0);
    chk("sat.u1.ch0.pos", int'(pos_w[1][1:0]), 3);
    chk("sat.u1.ch0.steps", n_step[1][0], 4);
    for (int k = 0; k < 4; k++) cycle4(0, 1'b0, 6);
    chk("sat_low.u1.ch0.pos", int'(pos_w[1][1:0]), 0);
    chk("sat_low.u1.ch0.steps", n_step[1][0], 8);

    seq(0, 1, 1); seq(0, 0, 6); seq(0, 2, 1); seq(0, 0, 6); seq(0, 3, 1); seq(0, 0, 6);
    seq(0, 1, 6); seq(0, 0, 6); seq(0, 2, 6); seq(0, 0, 6);
    seq(0, 1, 6); seq(0, 3, 6); seq(0, 1, 6); seq(0, 0, 6);
    chk("glitch.u0.ch0.steps", n_step[0][0], 8);
    chk("glitch.u0.ch0.errs", n_err[0][0], 0);
    seq(0, 2, 6); seq(0, 3, 6); seq(0, 0, 6);
    chk("illegal.u0.ch0.errs", n_err[0][0], 1);
    chk("illegal.u0.ch0.steps", n_step[0][0], 8);
    chk("illegal.u0.ch0.pos", int'(pos_w[0][1:0]), 0);

    for (int i = 0; i < 4; i++) begin
      seq(1, cwq[i], 6);
      chk($sformatf("qtr.u2.ch1.pos%0d", i), int'(pos_w[2][3:2]), (i + 1) % 4);
    end
    chk("qtr.u2.ch1.steps", n_step[2][1], 4);
    seq(1, 1, 6);
    seq(1, 2, 6);
    chk("qtr.u2.ch1.errs", n_err[2][1], 1);
    chk("qtr_err.u2.ch1.pos", int'(pos_w[2][3:2]), 1);
    seq(1, 0, 6);

    clr = 2'b10; hold(1); clr = 2'b00; hold(2);
    for (int i = 0; i < 3; i++) begin
      set_ph(0, cwq[i]); set_ph(1, ccwq[i]); hold(6);
    end
    set_ph(0, 0); set_ph(1, 0);
    hold(4);
    clr[0] = 1'b1; clr_cyc = cyc + 1;
    hold(1);
    clr[0] = 1'b0;
    hold(4);
    chk("clear.u0.ch0.pos", int'(pos_w[0][1:0]), 0);
    chk("clear.u0.ch0.step_edge", step_cyc[0][0], clr_cyc);
    chk("clear.u0.ch0.steps", n_step[0][0], 9);
    chk("ccw.u0.ch1.pos", int'(pos_w[0][3:2]), 3);

    seq(0, 1, 6); seq(0, 3, 6);
    rst_n = 1'b0;
    hold(2);
    for (int u = 0; u < NU; u++) begin
      chk($sformatf("midrst.u%0d.pos", u), int'(pos_w[u]), 0);
      chk($sformatf("midrst.u%0d.step", u), int'(stp_w[u]), 0);
      chk($sformatf("midrst.u%0d.cw", u), int'(cw_w[u]), 0);
      chk($sformatf("midrst.u%0d.err", u), int'(err_w[u]), 0);
    end
    rst_n = 1'b1;
    hold(8);
    seq(0, 0, 8);
    chk("midrst.u0.ch0.steps", n_step[0][0], 9);
    chk("midrst.u0.ch0.pos", int'(pos_w[0][1:0]), 0);

    gi[0] = 0; gi[1] = 0;
    for (int t = 0; t < 4000; t++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(3) == 0) begin
          r = $urandom_range(19);
          if (r < 9)       gi[c] = (gi[c] + 1) % 4;
          else if (r < 18) gi[c] = (gi[c] + 3) % 4;
          else             gi[c] = (gi[c] + 2) % 4;
          set_ph(c, gseq[gi[c]]);
        end
      end
      clr   = ($urandom_range(40) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rst_n = ($urandom_range(600) != 0);
      hold(1);
    end
    clr = 2'b00;
    rst_n = 1'b1;
    hold(10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
